background_pixel_fifo: RTL and testbench
========================================

# background_pixel_fifo

Background pixel FIFO for the PPU pixel pipeline, directly downstream of the background fetcher. It accepts 8-pixel tile rows from the fetcher and discards the first SCX[2:0] pixels of each scanline for fine scroll. It then shifts one 2-bit colour index per T-cycle towards the pixel mixer/LCD stage. It also owns the scanline X position counter and the FIFO-empty flag that pace the fetcher.

## Interface
Parameters:
- DEPTH, 16: pixel slots; must be ≥ 8 and a multiple of 8.
- X_MAX, 160: visible pixels per scanline.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_n_in  input  1  reset; one clock; synchronous, active-low.
- tclk_in  input  1  T-cycle enable, one clk wide.
- line_start_in  input  1  pulse at entry to mode 3 (pixel transfer) for the current scanline.
- SCX_in  input  8  SCX register; only bits [2:0] are used.
- valid_pixels_in  input  1  fetcher row valid; sampled only when tclk_in is high.
- pixels_in  input  2×8  row pixels; index 0 is leftmost/first out.
- pause_in  input  1  sprite fetch in progress; freezes popping.
- empty_out  output  1  FIFO holds zero pixels; fed to the fetcher.
- X_out  output  $clog2(X_MAX)  next visible X to emit.
- pixel_out  output  2  colour index of the emitted pixel.
- pixel_valid_out  output  1  one-clk strobe per emitted pixel.
- line_done_out  output  1  one-clk strobe after pixel X_MAX-1 is emitted.

## Operation
- States: IDLE, DISCARD, SHIFT, DONE.
- IDLE/DONE: no pops. Pushes are still accepted.
- line_start_in (any clk, tclk-independent):
  - flush: count ← 0; X ← 0.
  - latch discard ← SCX_in[2:0].
  - state ← DISCARD, or straight to SHIFT if the latched value is 0.
  - This overrides every other event in the same clk, including a push.
- Push (tclk_in && valid_pixels_in):
  - accepted iff count ≤ DEPTH−8; the 8 pixels are appended at the tail in index order.
  - otherwise the row is dropped and count is unchanged.
- Pop (tclk_in && count>0 && !pause_in && state∈{DISCARD,SHIFT}): removes the head pixel.
  - DISCARD: pixel is dropped and discard decrements. On the pop that takes discard to 0, state ← SHIFT.
  - SHIFT: pixel goes to pixel_out with pixel_valid_out=1, and X increments. On the pop emitting X=X_MAX−1: state ← DONE, line_done_out=1, X holds at X_MAX−1.
- Simultaneous push and pop on the same tclk:
  - pop takes the old head; the new row goes to the tail; count ← count+7.
  - The push acceptance test uses the pre-pop count.
- With count=0, a push and a would-be pop on the same tclk give a push only; the first pop comes on the next tclk.
- pause_in high: no pop and X frozen; pushes are still accepted. Popping resumes on the first tclk with pause_in low.
- empty_out = (count==0), registered, updated in the same clk as count.
- Arithmetic: count is $clog2(DEPTH+1) bits and never wraps (guarded by the acceptance rule). X saturates at X_MAX−1.

## Timing
- All outputs are registered and update on the clk edge where tclk_in (or line_start_in) is sampled.
- Pop-to-output latency: 1 clk.
- pixel_valid_out and line_done_out are high for exactly one clk per event.
- First visible pixel: earliest is 1 clk after the tclk following the push into an empty FIFO, plus one tclk per discarded pixel.
- Reset values: empty_out=1, X_out=0, pixel_out=0, pixel_valid_out=0, line_done_out=0, state=IDLE, count=0, discard=0.
- Reset mid-line flushes everything. The first pop after reset requires a line_start_in.

## Configuration
- BG_FIFO_SCX_DISCARD_EN defined: fine-scroll discard as above.
- Undefined: DISCARD state and discard register are removed. line_start_in goes straight to SHIFT. SCX_in is ignored but the port is kept.

## Structure
- Shared package ppu_pkg holds:
  - the pixel colour-index typedef (logic [1:0]);
  - the state enum BgFifoState;
  - the constant BG_ROW_PIXELS = 8.
- One sub-module is natural: PixelShiftQueue, holding DEPTH×2-bit storage plus count, with push8/pop1/flush ports. The top level holds the FSM, discard counter, X counter and output registers.

## Test plan
- Reset with rst_n_in low, then release → empty_out=1, X_out=0, all strobes 0; no pops without line_start_in.
- line_start with SCX=0, then push row {0,1,2,3,3,2,1,0} → pixel_out emits 0,1,2,3,3,2,1,0 on consecutive tclks, X_out 0→8, empty_out=1 after the 8th pop.
- line_start with SCX=5, then push row {3,2,1,0,1,2,3,0} → first emitted pixel is 2 (index 5); X=0 is assigned to it; 3 pixels are emitted.
- pause_in held for 6 tclks mid-row with count=4 → no pixel_valid_out and X frozen; the next pixel emits on the first tclk after release; a row pushed during the pause gives count=12.
- With count=9 (DEPTH=16), push → dropped, count stays 9; with count=8, simultaneous push+pop → count=15 and order is preserved.
- Full line of 20 rows, SCX=0 → exactly 160 pixel_valid_out strobes, then a line_done_out pulse and no further pops; line_start_in mid-line flushes to count=0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU pipeline types: pixel colour index, background FIFO states and row geometry.
package ppu_pkg;

  localparam int BG_ROW_PIXELS = 8;

  typedef logic [1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISCARD = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } BgFifoState;

  // Extract pixel idx from a packed fetcher row (index 0 in the low bits).
  function automatic pixel_t row_pixel(input logic [2*BG_ROW_PIXELS-1:0] row, input int idx);
    return row[2*idx +: 2];
  endfunction

endpackage

// File: rtl/pixel_shift_queue.sv
// Pixel shift queue: DEPTH x 2-bit slots, head at slot 0, 8-pixel row push, single pop, flush.
module pixel_shift_queue
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         flush_in,
  input  logic                         push_in,
  input  logic [2*BG_ROW_PIXELS-1:0]   row_in,
  input  logic                         pop_in,
  output logic [1:0]                   head_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out,
  output logic                         empty_out
);

  localparam int CW = $clog2(DEPTH+1);

  pixel_t        mem_r      [DEPTH];
  pixel_t        mem_next_s [DEPTH];
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          empty_r;
  logic          push_ok_s;
  logic          pop_ok_s;
  int            tail_s;

  assign pop_ok_s  = pop_in && !flush_in && (count_r != CW'(0));
  assign push_ok_s = push_in && !flush_in && (count_r <= CW'(DEPTH - BG_ROW_PIXELS));

  // Next storage: shift toward the head on pop, then place the row at the post-pop tail.
  always_comb begin
    tail_s = int'(count_r) - int'(pop_ok_s);
    for (int i = 0; i < DEPTH; i++) begin
      if (pop_ok_s) begin
        mem_next_s[i] = (i == DEPTH-1) ? 2'd0 : mem_r[(i+1) % DEPTH];
      end else begin
        mem_next_s[i] = mem_r[i];
      end
      if (push_ok_s && (i >= tail_s) && (i < tail_s + BG_ROW_PIXELS)) begin
        mem_next_s[i] = row_pixel(row_in, i - tail_s);
      end else begin
        mem_next_s[i] = mem_next_s[i];
      end
    end
    if (flush_in) begin
      count_next_s = CW'(0);
    end else begin
      count_next_s = count_r + (push_ok_s ? CW'(BG_ROW_PIXELS) : CW'(0)) - (pop_ok_s ? CW'(1) : CW'(0));
    end
  end

  // Storage, occupancy and empty flag registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count_r <= CW'(0);
      empty_r <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 2'd0;
    end else begin
      count_r <= count_next_s;
      empty_r <= (count_next_s == CW'(0));
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= mem_next_s[i];
    end
  end

  assign head_out  = mem_r[0];
  assign count_out = count_r;
  assign empty_out = empty_r;

endmodule

// File: rtl/background_pixel_fifo.sv
// Background pixel FIFO: fine-scroll discard, per-T-cycle pixel shift-out, scanline X counter.
// Optional SCX fine-scroll discard is enabled by defining BG_FIFO_SCX_DISCARD_EN.
module background_pixel_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int X_MAX = 160
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       tclk_in,
  input  logic                       line_start_in,
  input  logic [7:0]                 SCX_in,
  input  logic                       valid_pixels_in,
  input  logic [2*BG_ROW_PIXELS-1:0] pixels_in,
  input  logic                       pause_in,
  output logic                       empty_out,
  output logic [$clog2(X_MAX)-1:0]   X_out,
  output logic [1:0]                 pixel_out,
  output logic                       pixel_valid_out,
  output logic                       line_done_out
);

  localparam int XW = $clog2(X_MAX);
  localparam int CW = $clog2(DEPTH+1);

  BgFifoState    state_r, state_next_s;
  logic [XW-1:0] x_r, x_next_s;
  pixel_t        pixel_r, pixel_next_s;
  logic          valid_r, valid_next_s;
  logic          done_r, done_next_s;
  logic          pop_s;
  logic [1:0]    head_s;
  logic [CW-1:0] count_s;
  logic          empty_s;

`ifdef BG_FIFO_SCX_DISCARD_EN
  logic [2:0]    discard_r, discard_next_s;
  logic          scx_unused_s;
  assign scx_unused_s = ^SCX_in[7:3];
`else
  logic          scx_unused_s;
  assign scx_unused_s = ^SCX_in;
`endif

  pixel_shift_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .flush_in  (line_start_in),
    .push_in   (tclk_in && valid_pixels_in),
    .row_in    (pixels_in),
    .pop_in    (pop_s),
    .head_out  (head_s),
    .count_out (count_s),
    .empty_out (empty_s)
  );

  // Next-state, pop decision and output values; line start overrides everything.
  always_comb begin
    state_next_s = state_r;
    x_next_s     = x_r;
    pixel_next_s = pixel_r;
    valid_next_s = 1'b0;
    done_next_s  = 1'b0;
    pop_s        = 1'b0;
`ifdef BG_FIFO_SCX_DISCARD_EN
    discard_next_s = discard_r;
`endif
    if (line_start_in) begin
      x_next_s = XW'(0);
`ifdef BG_FIFO_SCX_DISCARD_EN
      discard_next_s = SCX_in[2:0];
      state_next_s   = (SCX_in[2:0] == 3'd0) ? SHIFT : DISCARD;
`else
      state_next_s   = SHIFT;
`endif
    end else if (tclk_in && (count_s != CW'(0)) && !pause_in) begin
      case (state_r)
`ifdef BG_FIFO_SCX_DISCARD_EN
        DISCARD: begin
          pop_s          = 1'b1;
          discard_next_s = discard_r - 3'd1;
          if (discard_r == 3'd1) begin
            state_next_s = SHIFT;
          end else begin
            state_next_s = DISCARD;
          end
        end
`endif
        SHIFT: begin
          pop_s        = 1'b1;
          valid_next_s = 1'b1;
          pixel_next_s = head_s;
          if (x_r == XW'(X_MAX-1)) begin
            state_next_s = DONE;
            done_next_s  = 1'b1;
          end else begin
            x_next_s = x_r + XW'(1);
          end
        end
        default: begin
          pop_s = 1'b0;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r <= IDLE;
      x_r     <= XW'(0);
      pixel_r <= 2'd0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
`ifdef BG_FIFO_SCX_DISCARD_EN
      discard_r <= 3'd0;
`endif
    end else begin
      state_r <= state_next_s;
      x_r     <= x_next_s;
      pixel_r <= pixel_next_s;
      valid_r <= valid_next_s;
      done_r  <= done_next_s;
`ifdef BG_FIFO_SCX_DISCARD_EN
      discard_r <= discard_next_s;
`endif
    end
  end

  assign empty_out       = empty_s;
  assign X_out           = x_r;
  assign pixel_out       = pixel_r;
  assign pixel_valid_out = valid_r;
  assign line_done_out   = done_r;

endmodule

// File: tb/tb_background_pixel_fifo.sv
// Directed self-checking bench for background_pixel_fifo (DEPTH=16, X_MAX=160).
module tb_background_pixel_fifo;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        tclk_in;
  logic        line_start_in;
  logic [7:0]  SCX_in;
  logic        valid_pixels_in;
  logic [15:0] pixels_in;
  logic        pause_in;
  logic        empty_out;
  logic [7:0]  X_out;
  logic [1:0]  pixel_out;
  logic        pixel_valid_out;
  logic        line_done_out;

  int checks = 0;
  int errors = 0;

  background_pixel_fifo #(.DEPTH(16), .X_MAX(160)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .tclk_in         (tclk_in),
    .line_start_in   (line_start_in),
    .SCX_in          (SCX_in),
    .valid_pixels_in (valid_pixels_in),
    .pixels_in       (pixels_in),
    .pause_in        (pause_in),
    .empty_out       (empty_out),
    .X_out           (X_out),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .line_done_out   (line_done_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] mk_row(input int p0, p1, p2, p3, p4, p5, p6, p7);
    logic [15:0] r;
    r = {p7[1:0], p6[1:0], p5[1:0], p4[1:0], p3[1:0], p2[1:0], p1[1:0], p0[1:0]};
    return r;
  endfunction

  // One T-cycle; outputs for that edge are stable when the task returns.
  task automatic tc(input logic push, input logic [15:0] row);
    @(negedge clk_in);
    tclk_in = 1'b1; valid_pixels_in = push; pixels_in = row;
    @(negedge clk_in);
    tclk_in = 1'b0; valid_pixels_in = 1'b0;
  endtask

  task automatic ls(input logic [7:0] scx);
    @(negedge clk_in);
    line_start_in = 1'b1; SCX_in = scx;
    @(negedge clk_in);
    line_start_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty_out); end
    checks++; if (X_out !== 8'd0) begin errors++; $display("FAIL reset_x got %0d want 0", X_out); end
    checks++; if (pixel_out !== 2'd0) begin errors++; $display("FAIL reset_pixel got %0d want 0", pixel_out); end
    checks++; if ({pixel_valid_out, line_done_out} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {pixel_valid_out, line_done_out}); end
    tc(1'b1, mk_row(1, 1, 1, 1, 1, 1, 1, 1));
    checks++; if (empty_out !== 1'b0) begin errors++; $display("FAIL idle_push_empty got %0b want 0", empty_out); end
    for (int i = 0; i < 3; i++) begin
      tc(1'b0, 16'h0000);
      checks++; if (pixel_valid_out !== 1'b0) begin errors++; $display("FAIL idle_no_pop got %0b want 0", pixel_valid_out); end
    end
  endtask

  task automatic test_scx0();
    int exp_px[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
    ls(8'd0);
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL scx0_flush_empty got %0b want 1", empty_out); end
    tc(1'b1, mk_row(0, 1, 2, 3, 3, 2, 1, 0));
    checks++; if (pixel_valid_out !== 1'b0) begin errors++; $display("FAIL scx0_push_only got %0b want 0", pixel_valid_out); end
    for (int i = 0; i < 8; i++) begin
      tc(1'b0, 16'h0000);
      checks++; if (pixel_valid_out !== 1'b1 || pixel_out !== exp_px[i][1:0]) begin
        errors++; $display("FAIL scx0_pixel%0d got v=%0b p=%0d want v=1 p=%0d", i, pixel_valid_out, pixel_out, exp_px[i]); end
      checks++; if (X_out !== 8'(i + 1)) begin errors++; $display("FAIL scx0_x%0d got %0d want %0d", i, X_out, i + 1); end
      checks++; if (empty_out !== (i == 7)) begin errors++; $display("FAIL scx0_empty%0d got %0b want %0b", i, empty_out, i == 7); end
    end
  endtask

  task automatic test_scx5();
    int n_emit = 0;
    int first_px = -1;
`ifdef BG_FIFO_SCX_DISCARD_EN
    int exp_n = 3; int exp_first = 2;
`else
    int exp_n = 8; int exp_first = 3;
`endif
    ls(8'd5);
    tc(1'b1, mk_row(3, 2, 1, 0, 1, 2, 3, 0));
    for (int i = 0; i < 10; i++) begin
      tc(1'b0, 16'h0000);
      if (pixel_valid_out === 1'b1) begin
        if (n_emit == 0) first_px = int'(pixel_out);
        n_emit++;
      end
    end
    checks++; if (first_px !== exp_first) begin errors++; $display("FAIL scx5_first got %0d want %0d", first_px, exp_first); end
    checks++; if (n_emit !== exp_n) begin errors++; $display("FAIL scx5_count got %0d want %0d", n_emit, exp_n); end
    checks++; if (X_out !== 8'(exp_n)) begin errors++; $display("FAIL scx5_x got %0d want %0d", X_out, exp_n); end
  endtask

  task automatic test_pause();
    logic [1:0] exp_q[$];
    logic [1:0] e;
    ls(8'd0);
    tc(1'b1, mk_row(0, 1, 2, 3, 0, 1, 2, 3));
    repeat (4) tc(1'b0, 16'h0000);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    pause_in = 1'b1;
    for (int p = 0; p < 6; p++) begin
      tc(p == 1, mk_row(3, 3, 2, 2, 1, 1, 0, 0));
      checks++; if (pixel_valid_out !== 1'b0 || X_out !== 8'd4) begin
        errors++; $display("FAIL pause_hold%0d got v=%0b x=%0d want v=0 x=4", p, pixel_valid_out, X_out); end
    end
    pause_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tc(1'b0, 16'h0000);
      e = exp_q[i];
      checks++; if (pixel_valid_out !== 1'b1 || pixel_out !== e) begin
        errors++; $display("FAIL pause_resume%0d got v=%0b p=%0d want v=1 p=%0d", i, pixel_valid_out, pixel_out, e); end
      if (i == 0) begin
        checks++; if (X_out !== 8'd5) begin errors++; $display("FAIL pause_x_resume got %0d want 5", X_out); end
      end
    end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL pause_count12 got empty=%0b want 1", empty_out); end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_q[$];
    logic [1:0] e;
    ls(8'd0);
    tc(1'b1, mk_row(1, 2, 3, 0, 1, 2, 3, 0));
    tc(1'b1, mk_row(3, 3, 2, 2, 1, 1, 0, 0));
    checks++; if (pixel_valid_out !== 1'b1 || pixel_out !== 2'd1) begin
      errors++; $display("FAIL ovf_pushpop got v=%0b p=%0d want v=1 p=1", pixel_valid_out, pixel_out); end
    exp_q = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 6; i++) begin
      tc(1'b0, 16'h0000);
      e = exp_q[i];
      checks++; if (pixel_out !== e) begin errors++; $display("FAIL ovf_r1_%0d got %0d want %0d", i, pixel_out, e); end
    end
    pause_in = 1'b1;
    tc(1'b1, mk_row(2, 2, 2, 2, 2, 2, 2, 2));
    pause_in = 1'b0;
    exp_q = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 9; i++) begin
      tc(1'b0, 16'h0000);
      e = exp_q[i];
      checks++; if (pixel_valid_out !== 1'b1 || pixel_out !== e) begin
        errors++; $display("FAIL ovf_drain%0d got v=%0b p=%0d want v=1 p=%0d", i, pixel_valid_out, pixel_out, e); end
    end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL ovf_dropped got empty=%0b want 1", empty_out); end
    tc(1'b0, 16'h0000);
    checks++; if (pixel_valid_out !== 1'b0) begin errors++; $display("FAIL ovf_extra_pop got %0b want 0", pixel_valid_out); end
  endtask

  task automatic test_full_line();
    int mc = 0; int rows = 0; int k = 0; int dones = 0; int bad = 0;
    logic push; logic pop_m; logic [15:0] row; logic [1:0] e;
    ls(8'd0);
    for (int t = 0; t < 400; t++) begin
      push = (rows < 20) && (mc <= 8);
      for (int i = 0; i < 8; i++) row[2*i +: 2] = 2'((rows + i) % 4);
      pop_m = (mc > 0) && (dones == 0);
      tc(push, row);
      mc = mc + (push ? 8 : 0) - (pop_m ? 1 : 0);
      if (push) rows++;
      if (pixel_valid_out === 1'b1) begin
        e = 2'(((k / 8) + (k % 8)) % 4);
        if (pixel_out !== e && bad == 0) begin
          bad = 1; $display("FAIL line_pixel%0d got %0d want %0d", k, pixel_out, e);
        end
        k++;
      end
      if (line_done_out === 1'b1) begin
        dones++;
        checks++; if (k !== 160) begin errors++; $display("FAIL line_done_at got %0d want 160", k); end
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL line_order got bad=%0d want 0", bad); end
    checks++; if (k !== 160) begin errors++; $display("FAIL line_strobes got %0d want 160", k); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL line_done_cnt got %0d want 1", dones); end
    checks++; if (X_out !== 8'd159) begin errors++; $display("FAIL line_x_sat got %0d want 159", X_out); end
    // Mid-line flush, including a push in the same clk as line start.
    ls(8'd0);
    tc(1'b1, mk_row(1, 1, 1, 1, 1, 1, 1, 1));
    tc(1'b1, mk_row(2, 2, 2, 2, 2, 2, 2, 2));
    ls(8'd0);
    checks++; if (empty_out !== 1'b1 || X_out !== 8'd0) begin
      errors++; $display("FAIL flush got empty=%0b x=%0d want empty=1 x=0", empty_out, X_out); end
    @(negedge clk_in);
    line_start_in = 1'b1; tclk_in = 1'b1; valid_pixels_in = 1'b1;
    @(negedge clk_in);
    line_start_in = 1'b0; tclk_in = 1'b0; valid_pixels_in = 1'b0;
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL ls_over_push got empty=%0b want 1", empty_out); end
    tc(1'b0, 16'h0000);
    checks++; if (pixel_valid_out !== 1'b0) begin errors++; $display("FAIL flush_no_pop got %0b want 0", pixel_valid_out); end
  endtask

  initial begin
    rst_n_in = 1'b0; tclk_in = 1'b0; line_start_in = 1'b0; SCX_in = 8'd0;
    valid_pixels_in = 1'b0; pixels_in = 16'h0000; pause_in = 1'b0;
    test_reset();
    test_scx0();
    test_scx5();
    test_pause();
    test_overflow();
    test_full_line();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
